// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data load/store share
// one memory port. Data normally has priority; a starvation counter hands the
// port to a waiting fetch after STARVE_LIMIT consecutive data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  // instruction requester
  input  logic        instr_read_in,
  input  logic [63:0] instr_address_in,
  output logic [63:0] instr_read_value_out,
  output logic        instr_stall_out,
  // data requester
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [63:0] data_address_in,
  input  logic [63:0] data_write_value_in,
  input  logic [7:0]  data_write_mask_in,
  output logic [63:0] data_read_value_out,
  output logic        data_stall_out,
  // memory side
  output logic        mem_valid_out,
  output logic        mem_write_out,
  output logic [63:0] mem_address_out,
  output logic [63:0] mem_write_value_out,
  output logic [7:0]  mem_write_mask_out,
  input  logic        mem_ready_in,
  input  logic [63:0] mem_read_value_in
);

  localparam int SW_RAW = $clog2(STARVE_LIMIT + 1);
  localparam int SW     = (SW_RAW > 2) ? SW_RAW : 2;
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

  state_t        state_q, state_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_write_q, mem_write_d;
  logic [63:0]   mem_address_q, mem_address_d;
  logic [63:0]   mem_write_value_q, mem_write_value_d;
  logic [7:0]    mem_write_mask_q, mem_write_mask_d;
  logic [63:0]   instr_value_q, instr_value_d;
  logic [63:0]   data_value_q, data_value_d;
  logic          instr_done_q, instr_done_d;
  logic          data_done_q, data_done_d;
  logic [SW-1:0] starve_q, starve_d;

  logic data_req;
  logic instr_ok, data_ok, starved, data_defer;
  logic grant_instr, grant_data;

  // Arbitration terms. A requester whose done flag is high is masked for that
  // cycle. If the data requester is still holding a request through its done
  // cycle it keeps its priority: the port idles one cycle rather than letting
  // the fetch slip in, unless the fetch is already starved.
  always_comb begin
    data_req    = data_read_in | data_write_in;
    instr_ok    = instr_read_in & ~instr_done_q;
    data_ok     = data_req & ~data_done_q;
    starved     = (starve_q == LIMIT);
    data_defer  = data_done_q & data_req & ~starved;
    grant_data  = data_ok & ~(instr_ok & starved);
    grant_instr = instr_ok & ~grant_data & ~data_defer;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d           = state_q;
    mem_valid_d       = mem_valid_q;
    mem_write_d       = mem_write_q;
    mem_address_d     = mem_address_q;
    mem_write_value_d = mem_write_value_q;
    mem_write_mask_d  = mem_write_mask_q;
    instr_value_d     = instr_value_q;
    data_value_d      = data_value_q;
    instr_done_d      = 1'b0;
    data_done_d       = 1'b0;
    starve_d          = starve_q;

    case (state_q)
      IDLE: begin
        if (!instr_read_in) starve_d = '0;
        if (grant_data) begin
          state_d           = DATA;
          mem_valid_d       = 1'b1;
          mem_write_d       = data_write_in;
          mem_address_d     = data_address_in;
          mem_write_value_d = data_write_in ? data_write_value_in : 64'd0;
          mem_write_mask_d  = data_write_in ? data_write_mask_in : 8'd0;
          if (instr_read_in && !starved) starve_d = starve_q + 1'b1;
        end else if (grant_instr) begin
          state_d           = INSTR;
          mem_valid_d       = 1'b1;
          mem_write_d       = 1'b0;
          mem_address_d     = instr_address_in;
          mem_write_value_d = 64'd0;
          mem_write_mask_d  = 8'd0;
          starve_d          = '0;
        end
      end
      INSTR, DATA: begin
        if (mem_ready_in) begin
          state_d           = IDLE;
          mem_valid_d       = 1'b0;
          mem_write_d       = 1'b0;
          mem_address_d     = 64'd0;
          mem_write_value_d = 64'd0;
          mem_write_mask_d  = 8'd0;
          if (state_q == INSTR) begin
            instr_value_d = mem_read_value_in;
            instr_done_d  = 1'b1;
          end else begin
            if (!mem_write_q) data_value_d = mem_read_value_in;
            data_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= IDLE;
      mem_valid_q       <= 1'b0;
      mem_write_q       <= 1'b0;
      mem_address_q     <= 64'd0;
      mem_write_value_q <= 64'd0;
      mem_write_mask_q  <= 8'd0;
      instr_value_q     <= 64'd0;
      data_value_q      <= 64'd0;
      instr_done_q      <= 1'b0;
      data_done_q       <= 1'b0;
      starve_q          <= '0;
    end else begin
      state_q           <= state_d;
      mem_valid_q       <= mem_valid_d;
      mem_write_q       <= mem_write_d;
      mem_address_q     <= mem_address_d;
      mem_write_value_q <= mem_write_value_d;
      mem_write_mask_q  <= mem_write_mask_d;
      instr_value_q     <= instr_value_d;
      data_value_q      <= data_value_d;
      instr_done_q      <= instr_done_d;
      data_done_q       <= data_done_d;
      starve_q          <= starve_d;
    end
  end

  // Output mapping; stalls are combinational from the live request.
  always_comb begin
    mem_valid_out        = mem_valid_q;
    mem_write_out        = mem_write_q;
    mem_address_out      = mem_address_q;
    mem_write_value_out  = mem_write_value_q;
    mem_write_mask_out   = mem_write_mask_q;
    instr_read_value_out = instr_value_q;
    data_read_value_out  = data_value_q;
    instr_stall_out      = instr_read_in & ~instr_done_q;
    data_stall_out       = data_req & ~data_done_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, fetch/load contention,
// starvation rotation, held request after done, reset mid-transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_read_in;
  logic [63:0] instr_address_in;
  logic [63:0] instr_read_value_out;
  logic        instr_stall_out;
  logic        data_read_in;
  logic        data_write_in;
  logic [63:0] data_address_in;
  logic [63:0] data_write_value_in;
  logic [7:0]  data_write_mask_in;
  logic [63:0] data_read_value_out;
  logic        data_stall_out;
  logic        mem_valid_out;
  logic        mem_write_out;
  logic [63:0] mem_address_out;
  logic [63:0] mem_write_value_out;
  logic [7:0]  mem_write_mask_out;
  logic        mem_ready_in;
  logic [63:0] mem_read_value_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .instr_read_in(instr_read_in), .instr_address_in(instr_address_in),
    .instr_read_value_out(instr_read_value_out), .instr_stall_out(instr_stall_out),
    .data_read_in(data_read_in), .data_write_in(data_write_in),
    .data_address_in(data_address_in), .data_write_value_in(data_write_value_in),
    .data_write_mask_in(data_write_mask_in), .data_read_value_out(data_read_value_out),
    .data_stall_out(data_stall_out),
    .mem_valid_out(mem_valid_out), .mem_write_out(mem_write_out),
    .mem_address_out(mem_address_out), .mem_write_value_out(mem_write_value_out),
    .mem_write_mask_out(mem_write_mask_out), .mem_ready_in(mem_ready_in),
    .mem_read_value_in(mem_read_value_in)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [63:0] grants [8];
  logic [63:0] exp_grants [8];
  int          ngrant;

  initial begin
    reset = 1'b1;
    instr_read_in = 0; instr_address_in = 0;
    data_read_in = 0; data_write_in = 0; data_address_in = 0;
    data_write_value_in = 0; data_write_mask_in = 0;
    mem_ready_in = 0; mem_read_value_in = 0;
    step(); step();
    check("rst_valid", 64'(mem_valid_out), 64'd0);
    check("rst_addr", mem_address_out, 64'd0);
    check("rst_ival", instr_read_value_out, 64'd0);
    check("rst_dval", data_read_value_out, 64'd0);
    reset = 1'b0;
    step();

    // Single fetch
    instr_read_in = 1; instr_address_in = 64'h100;
    #1;
    check("f_stall_req", 64'(instr_stall_out), 64'd1);
    step();
    check("f_valid", 64'(mem_valid_out), 64'd1);
    check("f_addr", mem_address_out, 64'h100);
    check("f_write", 64'(mem_write_out), 64'd0);
    instr_address_in = 64'h999;             // ignored while granted
    step();
    check("f_hold_addr", mem_address_out, 64'h100);
    check("f_hold_valid", 64'(mem_valid_out), 64'd1);
    mem_ready_in = 1; mem_read_value_in = 64'hDEAD;
    step();
    check("f_done_valid", 64'(mem_valid_out), 64'd0);
    check("f_done_stall", 64'(instr_stall_out), 64'd0);
    check("f_value", instr_read_value_out, 64'hDEAD);
    mem_ready_in = 0;
    step();                                 // request held past done
    check("f_no_regrant", 64'(mem_valid_out), 64'd0);
    check("f_stall_again", 64'(instr_stall_out), 64'd1);
    instr_read_in = 0; instr_address_in = 0;
    mem_ready_in = 1; mem_read_value_in = 64'hBAD;
    step();                                 // ready ignored in IDLE
    check("idle_ready_valid", 64'(mem_valid_out), 64'd0);
    check("idle_ready_ival", instr_read_value_out, 64'hDEAD);

    // Store
    data_write_in = 1; data_address_in = 64'h200;
    data_write_value_in = 64'h1122334455667788; data_write_mask_in = 8'h0F;
    #1;
    check("s_stall_req", 64'(data_stall_out), 64'd1);
    step();
    check("s_valid", 64'(mem_valid_out), 64'd1);
    check("s_write", 64'(mem_write_out), 64'd1);
    check("s_mask", 64'(mem_write_mask_out), 64'h0F);
    check("s_wval", mem_write_value_out, 64'h1122334455667788);
    check("s_addr", mem_address_out, 64'h200);
    step();
    check("s_done_stall", 64'(data_stall_out), 64'd0);
    check("s_dval_kept", data_read_value_out, 64'd0);
    data_write_in = 0; data_write_value_in = 0; data_write_mask_in = 0;
    step();

    // Simultaneous fetch and load
    instr_read_in = 1; instr_address_in = 64'h300;
    data_read_in = 1; data_address_in = 64'h400;
    mem_read_value_in = 64'h55;
    step();
    check("c_first_addr", mem_address_out, 64'h400);
    check("c_first_write", 64'(mem_write_out), 64'd0);
    check("c_first_mask", 64'(mem_write_mask_out), 64'd0);
    step();
    check("c_gap_valid", 64'(mem_valid_out), 64'd0);
    check("c_dval", data_read_value_out, 64'h55);
    check("c_istall", 64'(instr_stall_out), 64'd1);
    data_read_in = 0; mem_read_value_in = 64'h66;
    step();
    check("c_second_valid", 64'(mem_valid_out), 64'd1);
    check("c_second_addr", mem_address_out, 64'h300);
    step();
    check("c_ival", instr_read_value_out, 64'h66);
    instr_read_in = 0;
    step();

    // Starvation rotation: 3 data grants then 1 fetch, repeating
    instr_read_in = 1; instr_address_in = 64'h500;
    data_read_in = 1; data_address_in = 64'h600;
    mem_read_value_in = 64'hABCD;
    exp_grants = '{64'h600, 64'h600, 64'h600, 64'h500,
                   64'h600, 64'h600, 64'h600, 64'h500};
    ngrant = 0;
    for (int i = 0; i < 60 && ngrant < 8; i++) begin
      step();
      if (mem_valid_out) begin
        grants[ngrant] = mem_address_out;
        ngrant++;
      end
    end
    check("sv_count", 64'(ngrant), 64'd8);
    for (int i = 0; i < ngrant; i++)
      check($sformatf("sv_grant%0d", i), grants[i], exp_grants[i]);
    instr_read_in = 0; data_read_in = 0;
    step(); step(); step();

    // Reset mid-transaction
    mem_ready_in = 0;
    data_read_in = 1; data_address_in = 64'h700;
    step();
    check("r_valid", 64'(mem_valid_out), 64'd1);
    step();
    reset = 1; mem_ready_in = 1;            // reset wins over ready
    step();
    check("r_valid_clr", 64'(mem_valid_out), 64'd0);
    check("r_stall", 64'(data_stall_out), 64'd1);
    check("r_dval_clr", data_read_value_out, 64'd0);
    check("r_ival_clr", instr_read_value_out, 64'd0);
    reset = 0; mem_ready_in = 0; mem_read_value_in = 64'h7777;
    step();
    check("r_regrant", 64'(mem_valid_out), 64'd1);
    check("r_regrant_addr", mem_address_out, 64'h700);
    mem_ready_in = 1;
    step();
    check("r_dval", data_read_value_out, 64'h7777);
    check("r_done_stall", 64'(data_stall_out), 64'd0);
    data_read_in = 0; mem_ready_in = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  clock, all state on rising edge; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have instruction requester ports: instr_read_in  in  1  fetch request; instr_address_in  in  64  fetch address; instr_read_value_out  out  64  fetched instruction word; instr_stall_out  out  1  fetch must hold.
REQ-003 SHALL have data requester ports: data_read_in  in  1; data_write_in  in  1; data_address_in  in  64; data_write_value_in  in  64; data_write_mask_in  in  8  byte enables; data_read_value_out  out  64; data_stall_out  out  1.
REQ-004 SHALL have memory ports: mem_valid_out  out  1; mem_write_out  out  1; mem_address_out  out  64; mem_write_value_out  out  64; mem_write_mask_out  out  8; mem_ready_in  in  1  transaction complete this cycle; mem_read_value_in  in  64.
REQ-005 SHALL use parameter STARVE_LIMIT, default 3, meaning max consecutive data grants while a fetch waits.

Function
REQ-006 SHALL implement FSM states IDLE, INSTR, DATA.
REQ-007 SHALL, in IDLE, grant a pending unmasked request: data beats instruction unless starvation counter equals STARVE_LIMIT, then instruction wins.
REQ-008 SHALL, on grant at edge N, enter INSTR/DATA and from cycle N+1 drive mem_valid_out=1 with address, write value, mask and mem_write_out registered from the requester at edge N.
REQ-009 SHALL hold all mem_* outputs stable while mem_valid_out=1 and mem_ready_in=0.
REQ-010 SHALL, on a cycle with mem_valid_out=1 and mem_ready_in=1, return to IDLE, capture mem_read_value_in into the granted requester's read-value register (reads only), and set that requester's done flag for exactly the next cycle.
REQ-011 SHALL drive mem_valid_out=0 in IDLE; minimum transaction = 3 cycles request-to-done, no back-to-back mem_valid_out between transactions.
REQ-012 SHALL set instr_stall_out = instr_read_in AND NOT instr_done; data_stall_out = (data_read_in OR data_write_in) AND NOT data_done (combinational).
REQ-013 SHALL mask a requester from arbitration in the cycle its done flag is high, so a held, completed request is not regranted.
REQ-014 SHALL treat data_read_in and data_write_in both high as a write; mem_write_out=0 for reads and instruction fetches, mem_write_mask_out=0 for reads.
REQ-015 SHALL hold instr_read_value_out/data_read_value_out unchanged until that requester's next completed read; writes do not change data_read_value_out.
REQ-016 SHALL increment the 2-bit-min starvation counter on each data grant made while instr_read_in=1, saturating at STARVE_LIMIT, and clear it on every instruction grant or any IDLE cycle with instr_read_in=0.
REQ-017 SHALL require requesters to hold request and operands stable while stalled; changes during a grant are ignored until done.
REQ-018 SHALL ignore mem_ready_in while in IDLE.

Reset
REQ-019 SHALL, with reset high at an edge, enter IDLE, clear done flags, starvation counter, read-value registers (0) and all mem_* outputs (0), regardless of state.
REQ-020 SHALL abandon an in-flight transaction on reset without asserting done; stalls then follow REQ-012 with done=0.
REQ-021 SHALL give reset priority over mem_ready_in in the same cycle.

Verification
REQ-022 Single fetch: instr_read_in=1, addr 0x100, mem_ready_in high 2 cycles after mem_valid_out, value 0xDEAD -> mem_address_out=0x100, instr_stall_out low exactly one cycle, instr_read_value_out=0xDEAD.
REQ-023 Simultaneous fetch and load: both requested in IDLE -> data granted first, fetch granted after data done; no cycle with mem_valid_out=0 gap exceeding one.
REQ-024 Starvation: data requests continuously with fetch pending, mem_ready_in=1 always -> 3 data grants then 1 instruction grant, repeating.
REQ-025 Store: data_write_in=1, value 0x1122334455667788, mask 0x0F -> mem_write_out=1, mask 0x0F, data_read_value_out unchanged.
REQ-026 Reset mid-transaction: reset during DATA with mem_ready_in=0 -> next cycle mem_valid_out=0, data_stall_out=1 while request held, re-grant occurs after reset deasserts.
REQ-027 Held request after done: requester keeps request high one extra cycle after done -> no second grant in that cycle.
